// File: rtl/btn_debounce_if.sv
// Button debouncer signal bundle: raw level in, debounced level, edge strobes
// and press counter out. Clock and reset stay plain ports on the debouncer.
interface btn_debounce_if;
  logic       btn_in;
  logic       btn_level;
  logic       btn_rise;
  logic       btn_fall;
  logic [7:0] press_cnt;

  // Debouncer side: consumes the raw level, produces the filtered view.
  modport slave (
    input  btn_in,
    output btn_level, btn_rise, btn_fall, press_cnt
  );

  // Environment side: drives the raw level, observes the filtered view.
  modport master (
    output btn_in,
    input  btn_level, btn_rise, btn_fall, press_cnt
  );
endinterface

// File: rtl/btn_debounce.sv
// Button/switch debouncer. The raw input is synchronized through two flops,
// then a four-state FSM demands STABLE_CYCLES consecutive agreeing samples
// before accepting a level change. Any contrary sample while qualifying
// restarts the count. Accepted changes produce a one-cycle rise or fall
// strobe aligned with the level change; rises are counted modulo 256.
module btn_debounce #(
  parameter int STABLE_CYCLES = 100000,
  parameter int CNT_W         = 17
) (
  input  logic          clk,
  input  logic          reset,
  btn_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  // Terminal count: the last qualifying sample lands when cntr holds this.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cntr_q, cntr_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [7:0]       press_q, press_d;

  // Next-state logic: synchronizer shift plus the qualification FSM.
  always_comb begin
    s1_d    = bus.btn_in;
    s2_d    = s1_q;
    state_d = state_q;
    cntr_d  = cntr_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    press_d = press_q;
    case (state_q)
      STABLE_LO: begin
        if (s2_q) begin
          state_d = WAIT_HI;
          cntr_d  = '0;
        end
      end
      WAIT_HI: begin
        if (!s2_q) begin
          // Glitch: drop back silently, qualification restarts next time.
          state_d = STABLE_LO;
          cntr_d  = '0;
        end else if (cntr_q == LAST) begin
          state_d = STABLE_HI;
          cntr_d  = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
          press_d = press_q + 8'd1;
        end else begin
          cntr_d = cntr_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!s2_q) begin
          state_d = WAIT_LO;
          cntr_d  = '0;
        end
      end
      WAIT_LO: begin
        if (s2_q) begin
          state_d = STABLE_HI;
          cntr_d  = '0;
        end else if (cntr_q == LAST) begin
          state_d = STABLE_LO;
          cntr_d  = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cntr_d = cntr_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cntr_d  = '0;
      end
    endcase
  end

  // State register; reset wins over everything, including a same-cycle accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= STABLE_LO;
      cntr_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= 8'd0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cntr_q  <= cntr_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      press_q <= press_d;
    end
  end

  assign bus.btn_level = level_q;
  assign bus.btn_rise  = rise_q;
  assign bus.btn_fall  = fall_q;
  assign bus.press_cnt = press_q;

endmodule
